// File: rtl/game_round_ctrl.sv
// game_round_ctrl
// Round sequencer for the game timing path. Derives the 0.1 s time base from
// CLOCK10M with an internal prescaler and decides when game time runs,
// pauses, stops and expires.
//
// Optional feature macro: GAME_ROUND_READY_EN
//   defined   -> a READY pre-round countdown of READY_TENTHS tenths precedes PLAY
//   undefined -> start enters PLAY directly and ready_left is tied to 0
//
// Ports
//   CLOCK10M     in   10 MHz system clock, rising edge
//   KEY0         in   synchronous active-high reset
//   start        in   single-cycle command: begin a round (IDLE or OVER)
//   pause        in   single-cycle command: toggle PLAY / PAUSE
//   abort        in   single-cycle command: return to IDLE
//   state        out  IDLE=0, READY=1, PLAY=2, PAUSE=3, OVER=4
//   tenths_left  out  remaining round time in tenths
//   elapsed      out  consumed round time in tenths
//   ready_left   out  remaining pre-round countdown in tenths
//   tick         out  one-cycle pulse per tenth counted in READY or PLAY
//   time_up      out  one-cycle pulse when tenths_left reaches 0
//   running      out  high exactly when state is PLAY
module game_round_ctrl #(
    parameter int TICK_DIV     = 1000000,
    parameter int ROUND_TENTHS = 300,
    parameter int READY_TENTHS = 30,
    parameter int W            = 10
) (
    input  logic         CLOCK10M,
    input  logic         KEY0,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    output logic [2:0]   state,
    output logic [W-1:0] tenths_left,
    output logic [W-1:0] elapsed,
    output logic [W-1:0] ready_left,
    output logic         tick,
    output logic         time_up,
    output logic         running
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [W-1:0]  ONE        = W'(1);
    localparam logic [W-1:0]  ROUND_VAL  = W'(ROUND_TENTHS);

    // Elaboration-time guards on the legal parameter ranges.
    if (TICK_DIV < 1) begin : g_bad_div
        $error("TICK_DIV must be at least 1");
    end
    if (ROUND_TENTHS < 1 || ROUND_TENTHS >= (1 << W)) begin : g_bad_round
        $error("ROUND_TENTHS out of range 1..2^W-1");
    end
    if (READY_TENTHS < 1 || READY_TENTHS >= (1 << W)) begin : g_bad_ready
        $error("READY_TENTHS out of range 1..2^W-1");
    end

    logic [PW-1:0] presc, presc_nxt;
    logic [2:0]    state_nxt;
    logic [W-1:0]  tl_nxt, el_nxt;
    logic          tick_nxt, time_up_nxt;
    logic          counting, wrap;

`ifdef GAME_ROUND_READY_EN
    localparam logic [2:0]   S_START   = S_READY;
    localparam logic [W-1:0] READY_VAL = W'(READY_TENTHS);
    logic [W-1:0] ready_q, ready_nxt;
    assign counting   = (state == S_PLAY) || (state == S_READY);
    assign ready_left = ready_q;
`else
    localparam logic [2:0] S_START = S_PLAY;
    assign counting   = (state == S_PLAY);
    assign ready_left = '0;
`endif

    // Tick event: the prescaler steps from its last value back to 0.
    assign wrap = counting && (presc == PRESC_LAST);

    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        tl_nxt      = tenths_left;
        el_nxt      = elapsed;
        tick_nxt    = 1'b0;
        time_up_nxt = 1'b0;
`ifdef GAME_ROUND_READY_EN
        ready_nxt   = ready_q;
`endif
        // abort outranks everything, including a same-cycle tick. In IDLE the
        // counters are already zero, so clearing them there is a no-op.
        if (abort) begin
            state_nxt = S_IDLE;
            presc_nxt = '0;
            tl_nxt    = '0;
            el_nxt    = '0;
`ifdef GAME_ROUND_READY_EN
            ready_nxt = '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_nxt = S_START;
                        presc_nxt = '0;
                        tl_nxt    = ROUND_VAL;
                        el_nxt    = '0;
`ifdef GAME_ROUND_READY_EN
                        ready_nxt = READY_VAL;
`endif
                    end
                end
`ifdef GAME_ROUND_READY_EN
                S_READY: begin
                    if (wrap) begin
                        presc_nxt = '0;
                        tick_nxt  = 1'b1;
                        ready_nxt = ready_q - ONE;
                        // PLAY entry with a fresh prescaler (already 0 from the wrap).
                        if (ready_q == ONE) state_nxt = S_PLAY;
                    end else begin
                        presc_nxt = presc + PRESC_ONE;
                    end
                end
`endif
                S_PLAY: begin
                    presc_nxt = wrap ? '0 : presc + PRESC_ONE;
                    if (wrap) begin
                        tick_nxt = 1'b1;
                        tl_nxt   = tenths_left - ONE;
                        el_nxt   = elapsed + ONE;
                    end
                    // Expiry beats a same-cycle pause; a plain pause keeps the
                    // tick of that cycle and freezes the prescaler value.
                    if (wrap && tenths_left == ONE) begin
                        state_nxt   = S_OVER;
                        time_up_nxt = 1'b1;
                    end else if (pause) begin
                        state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    // Resume keeps the prescaler so the fractional tenth survives.
                    if (pause) state_nxt = S_PLAY;
                end
                default: begin
                    state_nxt = S_IDLE;
                    presc_nxt = '0;
                    tl_nxt    = '0;
                    el_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK10M) begin
        if (KEY0) begin
            state       <= S_IDLE;
            presc       <= '0;
            tenths_left <= '0;
            elapsed     <= '0;
            tick        <= 1'b0;
            time_up     <= 1'b0;
            running     <= 1'b0;
`ifdef GAME_ROUND_READY_EN
            ready_q     <= '0;
`endif
        end else begin
            state       <= state_nxt;
            presc       <= presc_nxt;
            tenths_left <= tl_nxt;
            elapsed     <= el_nxt;
            tick        <= tick_nxt;
            time_up     <= time_up_nxt;
            running     <= (state_nxt == S_PLAY);
`ifdef GAME_ROUND_READY_EN
            ready_q     <= ready_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed testbench for game_round_ctrl with TICK_DIV=4, ROUND_TENTHS=5,
// READY_TENTHS=2. Follows GAME_ROUND_READY_EN the same way the design does.
module tb_game_round_ctrl;

    localparam int W = 10;

    logic         CLOCK10M = 1'b0;
    logic         KEY0     = 1'b0;
    logic         start    = 1'b0;
    logic         pause    = 1'b0;
    logic         abort    = 1'b0;
    logic [2:0]   state;
    logic [W-1:0] tenths_left;
    logic [W-1:0] elapsed;
    logic [W-1:0] ready_left;
    logic         tick;
    logic         time_up;
    logic         running;

    int errors = 0;
    int checks = 0;

    game_round_ctrl #(
        .TICK_DIV    (4),
        .ROUND_TENTHS(5),
        .READY_TENTHS(2),
        .W           (W)
    ) dut (
        .CLOCK10M   (CLOCK10M),
        .KEY0       (KEY0),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .state      (state),
        .tenths_left(tenths_left),
        .elapsed    (elapsed),
        .ready_left (ready_left),
        .tick       (tick),
        .time_up    (time_up),
        .running    (running)
    );

    always #5 CLOCK10M = ~CLOCK10M;

    // One rising edge, then settle 1 time unit before sampling or driving.
    task automatic cyc();
        @(posedge CLOCK10M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},   32'(state),       32'd0);
        check({tag, "_left"},    32'(tenths_left), 32'd0);
        check({tag, "_elapsed"}, 32'(elapsed),     32'd0);
        check({tag, "_ready"},   32'(ready_left),  32'd0);
        check({tag, "_tick"},    32'(tick),        32'd0);
        check({tag, "_timeup"},  32'(time_up),     32'd0);
        check({tag, "_running"}, 32'(running),     32'd0);
    endtask

    // Pulses start and returns right after the edge that enters PLAY.
    task automatic start_round(input string tag);
        start = 1'b1;
        cyc();
        start = 1'b0;
`ifdef GAME_ROUND_READY_EN
        check({tag, "_rdy_state"}, 32'(state),      32'd1);
        check({tag, "_rdy_left"},  32'(ready_left), 32'd2);
        repeat (4) cyc();
        check({tag, "_rdy_tick1"}, 32'(tick),       32'd1);
        check({tag, "_rdy_left1"}, 32'(ready_left), 32'd1);
        check({tag, "_rdy_st1"},   32'(state),      32'd1);
        repeat (4) cyc();
        check({tag, "_rdy_left0"}, 32'(ready_left), 32'd0);
`else
        check({tag, "_ready_tied"}, 32'(ready_left), 32'd0);
`endif
        check({tag, "_state"},   32'(state),       32'd2);
        check({tag, "_running"}, 32'(running),     32'd1);
        check({tag, "_left"},    32'(tenths_left), 32'd5);
        check({tag, "_elapsed"}, 32'(elapsed),     32'd0);
    endtask

    initial begin
        // Power-up reset.
        KEY0 = 1'b1;
        repeat (2) cyc();
        KEY0 = 1'b0;
        check_all_zero("reset");

        // Full round: tick every 4 edges, expiry on the fifth tenth.
        start_round("r1");
        for (int k = 1; k <= 5; k++) begin
            repeat (3) begin
                cyc();
                check("r1_no_tick", 32'(tick), 32'd0);
            end
            cyc();
            check("r1_tick",    32'(tick),        32'd1);
            check("r1_left",    32'(tenths_left), 32'(5 - k));
            check("r1_elapsed", 32'(elapsed),     32'(k));
            check("r1_timeup",  32'(time_up),     32'(k == 5));
        end
        check("r1_over",      32'(state),   32'd4);
        check("r1_not_run",   32'(running), 32'd0);
        cyc();
        check("r1_timeup_once", 32'(time_up),     32'd0);
        check("r1_tick_off",    32'(tick),        32'd0);
        check("r1_hold_state",  32'(state),       32'd4);
        check("r1_hold_elap",   32'(elapsed),     32'd5);
        check("r1_hold_left",   32'(tenths_left), 32'd0);

        // Restart from OVER, ignored start in PLAY, pause/resume mid-tenth.
        start_round("r2");
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("r2_start_play_st",   32'(state),       32'd2);
        check("r2_start_play_left", 32'(tenths_left), 32'd5);
        cyc();
        cyc();
        check("r2_tick1",  32'(tick),        32'd1);
        check("r2_left1",  32'(tenths_left), 32'd4);
        check("r2_elap1",  32'(elapsed),     32'd1);
        // Prescaler reads 1 after this pause edge.
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("r2_paused",   32'(state),       32'd3);
        check("r2_p_run",    32'(running),     32'd0);
        check("r2_p_left",   32'(tenths_left), 32'd4);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("r2_start_pause", 32'(state), 32'd3);
        repeat (48) cyc();
        check("r2_p_state_end", 32'(state),       32'd3);
        check("r2_p_left_end",  32'(tenths_left), 32'd4);
        check("r2_p_elap_end",  32'(elapsed),     32'd1);
        check("r2_p_tick_end",  32'(tick),        32'd0);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("r2_resumed", 32'(state),   32'd2);
        check("r2_res_run", 32'(running), 32'd1);
        cyc();
        check("r2_r1_tick", 32'(tick), 32'd0);
        cyc();
        check("r2_r2_tick", 32'(tick), 32'd0);
        cyc();
        check("r2_r3_tick", 32'(tick),        32'd1);
        check("r2_r3_left", 32'(tenths_left), 32'd3);
        check("r2_r3_elap", 32'(elapsed),     32'd2);
        repeat (8) cyc();
        check("r2_left1b", 32'(tenths_left), 32'd1);
        check("r2_elap4",  32'(elapsed),     32'd4);
        repeat (3) cyc();
        // Pause coincides with the final tick: expiry wins.
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("r2_final_state",  32'(state),       32'd4);
        check("r2_final_timeup", 32'(time_up),     32'd1);
        check("r2_final_left",   32'(tenths_left), 32'd0);
        check("r2_final_elap",   32'(elapsed),     32'd5);
        cyc();
        check("r2_after_state",  32'(state),   32'd4);
        check("r2_after_timeup", 32'(time_up), 32'd0);

        // Abort in the same cycle as a tick.
        start_round("r3");
        repeat (3) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_all_zero("r3_abort");

        // pause in IDLE is ignored.
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("idle_pause", 32'(state), 32'd0);

        // Mid-round reset with a command on the reset edges.
        start_round("r4");
        repeat (2) cyc();
        KEY0  = 1'b1;
        start = 1'b1;
        cyc();
        check("r4_rst1_state", 32'(state), 32'd0);
        cyc();
        KEY0  = 1'b0;
        start = 1'b0;
        check_all_zero("r4_rst");
        cyc();
        check("r4_post_idle", 32'(state), 32'd0);

        // Prescaler must have been cleared by reset: first tick exactly 4 edges in.
        start_round("r5");
        repeat (3) cyc();
        check("r5_no_early_tick", 32'(tick), 32'd0);
        cyc();
        check("r5_tick",  32'(tick),        32'd1);
        check("r5_left",  32'(tenths_left), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
